// File: rtl/pu_fifo.sv
// Bus-attached queue PU: push on signal_wr, replay in order on signal_oe.
// Optional PU_FIFO_ERR_ATTR_EN flags underflow/overflow on attr_out[0].
module pu_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signal_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  signal_oe,
  input  logic                  signal_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int EW = ATTR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [EW-1:0]         mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [ATTR_WIDTH-1:0] aout_q, aout_d;
  logic                  do_push, do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // A pop frees a slot, so a push into a full queue survives it.
  assign do_pop  = signal_oe & ~empty & ~signal_clr;
  assign do_push = signal_wr & (~full | do_pop) & ~signal_clr;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    dout_d = '0;
    aout_d = '0;
    if (signal_clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (do_pop) begin
        {aout_d, dout_d} = mem_q[rd_q];
        rd_d = rd_q + ADDR_WIDTH'(1);
`ifdef PU_FIFO_ERR_ATTR_EN
        if (ovf_q) aout_d[0] = 1'b1;
`endif
      end
      if (signal_oe && empty) begin
        unf_d = 1'b1;
`ifdef PU_FIFO_ERR_ATTR_EN
        aout_d = ATTR_WIDTH'(1);
`endif
      end
      if (do_push) wr_d = wr_q + ADDR_WIDTH'(1);
      if (signal_wr && !do_push) ovf_d = 1'b1;
      cnt_d = cnt_q + (ADDR_WIDTH+1)'(do_push)
                    - (ADDR_WIDTH+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      dout_q <= '0;
      aout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      dout_q <= dout_d;
      aout_q <= aout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= {attr_in, data_in};
  end

  assign data_out  = dout_q;
  assign attr_out  = aout_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
